computation_sequencer: RTL
==========================

Name: computation_sequencer

Overview:
- Upstream driver for computation_device.
- Accepts one seed operand and a queued stream of {opcode, y} commands.
- Seeds the device, then issues one req pulse per command, giving the device's negedge-req accumulate commit a full cycle.
- Returns the device's final result with a valid/ready handshake. Lets software-facing logic chain N logic ops without knowing device timing.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- CNT_W, 8, width of op_count (saturating)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- init_valid  input  1  seed operand offered
- init_ready  output  1  seed accepted (high only in IDLE)
- init_x  input  4  seed operand
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO not full
- cmd_opcode  input  2  00 AND, 01 NAND, 10 NOR, 11 XOR
- cmd_y  input  4  second operand
- cmd_last  input  1  final command of chain
- dev_x  output  4  to device x
- dev_y  output  4  to device y
- dev_opcode  output  2  to device opcode
- dev_req  output  1  to device req
- dev_reset  output  1  to device reset (active-high seed strobe)
- dev_result  input  4  from device result
- res_valid  output  1  chain complete, res_data valid
- res_ready  input  1  consumer takes result
- res_data  output  4  final result
- busy  output  1  state != IDLE
- op_count  output  CNT_W  commands issued in current chain

Behaviour:
- All outputs registered. On reset low: state=IDLE, FIFO flushed, all dev_* = 0, res_valid=0, res_data=0, op_count=0, cmd_ready=1, init_ready=1.
- FIFO is independent of FSM; commands are accepted in any state, including IDLE (prefetch).
  - Push on cmd_valid && cmd_ready; cmd_ready = !full (registered).
  - Pop only when registered not-empty.
  - A push into an empty FIFO is poppable the following cycle.
  - Push and pop in the same cycle: count unchanged, pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: init_ready=1. On init_valid → SEED, latch init_x into dev_x, op_count=0.
  - SEED: dev_reset=1 for exactly one cycle → SETTLE.
  - SETTLE: dev_reset=0 for one cycle → WAIT_CMD.
  - WAIT_CMD: if FIFO not empty, pop, load dev_opcode/dev_y and the last flag → ISSUE. Otherwise stay; dev_req stays 0.
  - ISSUE: dev_req=1 for exactly one cycle; dev_y/dev_opcode stable throughout → RELEASE.
  - RELEASE: dev_req=0 (device commits on this falling edge); op_count+1, saturating at 2^CNT_W−1. If last → DONE, else → WAIT_CMD.
  - DONE: res_valid=1, res_data=dev_result captured on entry. Hold until res_ready → IDLE with res_valid=0. No new seed accepted in DONE.
- dev_y/dev_opcode change only on the WAIT_CMD→ISSUE transition. Minimum one dev_req-low cycle between pulses.
- Latency: seed accept → first dev_req = 3 cycles with FIFO prefilled; each further command = 3 cycles; last RELEASE → res_valid = 1 cycle.
- Reset asserted mid-chain: immediate return to reset values. A dev_req falling here may commit in the device; this is harmless because every chain reseeds.
- cmd_last never arriving: FSM waits in WAIT_CMD indefinitely; busy stays 1.

Decomposition:
- Shared package computation_pkg:
  - opcode enum (OP_AND, OP_NAND, OP_NOR, OP_XOR)
  - seq_state_t enum (IDLE, SEED, SETTLE, WAIT_CMD, ISSUE, RELEASE, DONE)
  - cmd_t packed struct {last, opcode[1:0], y[3:0]} (7 bits)
- Sub-module: cmd_fifo (synchronous FIFO of cmd_t, DEPTH entries, full/empty flags, async active-low reset).

Test Plan:
- Seed 4'hA, one cmd AND y=4'h6 last, model device attached → res_data=4'h2, op_count=1, dev_req high exactly 1 cycle.
- Seed 4'hC; XOR 4'h5, NOR 4'h2, NAND 4'h7 (last) prefilled → intermediates 9, 4, B; res_data=4'hB, op_count=3, three dev_req pulses spaced 3 cycles apart.
- Push 4 cmds with no seed → cmd_ready=0 after 4th, 5th not accepted; seed then drains all, cmd_ready returns 1 after first pop.
- res_ready held low 10 cycles in DONE → res_valid/res_data stable, init_valid ignored (init_ready=0); res_ready=1 → IDLE next cycle.
- Assert reset during ISSUE of 2nd of 3 cmds → all outputs to reset values same cycle, FIFO empty; fresh seed 4'h3 + AND 4'hF last → res_data=4'h3.
- Cmds trickle one every 7 cycles → FSM waits in WAIT_CMD with dev_req=0, final result still correct.

Source files
------------

// File: rtl/computation_sequencer_pkg.sv
// computation_sequencer_pkg: shared opcode, FSM state and command types
package computation_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_NAND = 2'b01,
        OP_NOR  = 2'b10,
        OP_XOR  = 2'b11
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        SETTLE,
        WAIT_CMD,
        ISSUE,
        RELEASE,
        DONE
    } seq_state_t;

    typedef struct packed {
        logic       last;
        opcode_t    opcode;
        logic [3:0] y;
    } cmd_t;

endpackage

// File: rtl/computation_sequencer_if.sv
// computation_sequencer_if: seed, command, device and result signals of the sequencer
interface computation_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             init_valid;
    logic             init_ready;
    logic [3:0]       init_x;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_opcode;
    logic [3:0]       cmd_y;
    logic             cmd_last;
    logic [3:0]       dev_x;
    logic [3:0]       dev_y;
    logic [1:0]       dev_opcode;
    logic             dev_req;
    logic             dev_reset;
    logic [3:0]       dev_result;
    logic             res_valid;
    logic             res_ready;
    logic [3:0]       res_data;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output init_valid, init_x, cmd_valid, cmd_opcode, cmd_y, cmd_last, dev_result, res_ready,
        input  init_ready, cmd_ready, dev_x, dev_y, dev_opcode, dev_req, dev_reset,
               res_valid, res_data, busy, op_count
    );

    modport slave (
        input  init_valid, init_x, cmd_valid, cmd_opcode, cmd_y, cmd_last, dev_result, res_ready,
        output init_ready, cmd_ready, dev_x, dev_y, dev_opcode, dev_req, dev_reset,
               res_valid, res_data, busy, op_count
    );
endinterface

// File: rtl/computation_sequencer_cmd_fifo.sv
// cmd_fifo: synchronous command FIFO with registered full/empty flags
module cmd_fifo
    import computation_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  cmd_t din_i,
    input  logic pop_i,
    output cmd_t dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;
    logic          full_q;
    logic          empty_q;
    logic          push;
    logic          pop;

    assign push    = push_i && !full_q;
    assign pop     = pop_i && !empty_q;
    assign cnt_d   = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign dout_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

    // Storage carries no reset; the empty flag guards every read of it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two; flags track the next count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop);
            cnt_q   <= cnt_d;
            full_q  <= cnt_d == (AW+1)'(DEPTH);
            empty_q <= cnt_d == '0;
        end
    end
endmodule

// File: rtl/computation_sequencer.sv
// computation_sequencer: seeds the device, issues one req pulse per queued command, returns the result
module computation_sequencer
    import computation_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    computation_sequencer_if.slave bus
);
    seq_state_t       state_q;
    logic [3:0]       dev_x_q;
    logic [3:0]       dev_y_q;
    logic [1:0]       dev_op_q;
    logic             dev_req_q;
    logic             dev_reset_q;
    logic             last_q;
    logic             res_valid_q;
    logic [3:0]       res_data_q;
    logic             busy_q;
    logic             init_ready_q;
    logic [CNT_W-1:0] op_count_q;
    cmd_t             head;
    logic             full;
    logic             empty;
    logic             pop;

    assign pop = state_q == WAIT_CMD && !empty;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push_i (bus.cmd_valid),
        .din_i  ('{last: bus.cmd_last, opcode: opcode_t'(bus.cmd_opcode), y: bus.cmd_y}),
        .pop_i  (pop),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    assign bus.init_ready = init_ready_q;
    assign bus.cmd_ready  = !full;
    assign bus.dev_x      = dev_x_q;
    assign bus.dev_y      = dev_y_q;
    assign bus.dev_opcode = dev_op_q;
    assign bus.dev_req    = dev_req_q;
    assign bus.dev_reset  = dev_reset_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.busy       = busy_q;
    assign bus.op_count   = op_count_q;

    // Sequencer FSM; every output is set on the edge entering the state it belongs to.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            dev_x_q      <= '0;
            dev_y_q      <= '0;
            dev_op_q     <= '0;
            dev_req_q    <= 1'b0;
            dev_reset_q  <= 1'b0;
            last_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            busy_q       <= 1'b0;
            init_ready_q <= 1'b1;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.init_valid) begin
                    state_q      <= SEED;
                    dev_x_q      <= bus.init_x;
                    op_count_q   <= '0;
                    dev_reset_q  <= 1'b1;
                    init_ready_q <= 1'b0;
                    busy_q       <= 1'b1;
                end
                SEED: begin
                    dev_reset_q <= 1'b0;
                    state_q     <= SETTLE;
                end
                SETTLE: state_q <= WAIT_CMD;
                WAIT_CMD: if (!empty) begin
                    dev_op_q  <= head.opcode;
                    dev_y_q   <= head.y;
                    last_q    <= head.last;
                    dev_req_q <= 1'b1;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    dev_req_q  <= 1'b0;
                    op_count_q <= &op_count_q ? op_count_q : op_count_q + 1'b1;
                    state_q    <= RELEASE;
                end
                // The device commits on the falling req edge, so its result is settled by the end of this cycle.
                RELEASE: if (last_q) begin
                    state_q     <= DONE;
                    res_valid_q <= 1'b1;
                    res_data_q  <= bus.dev_result;
                end else begin
                    state_q <= WAIT_CMD;
                end
                DONE: if (bus.res_ready) begin
                    state_q      <= IDLE;
                    res_valid_q  <= 1'b0;
                    busy_q       <= 1'b0;
                    init_ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
